// File: rtl/dpram_pkg.sv
// Shared constants and FSM state type for the true dual-port RAM controller.
package dpram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam int PRIO_A = 0;
    localparam int PRIO_B = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/dpram_rd_port.sv
// One port's read path: read-first/write-first selection and the rdata/rvalid registers.
// With DPRAM_OUT_REG_EN defined an extra output stage adds one cycle of latency.
module dpram_rd_port
    import dpram_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int READ_MODE = READ_FIRST
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_req,
    input  logic [WIDTH-1:0]   old_word,
    input  logic [WIDTH-1:0]   wr_word,
    input  logic [WIDTH/8-1:0] wr_be,
    output logic [WIDTH-1:0]   rdata,
    output logic               rvalid
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] merged_word;
    logic [WIDTH-1:0] rdata_d, rdata_q;
    logic             rvalid_d, rvalid_q;

    // merged_word is what the word will hold after the other port's write lands this edge
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                merged_word[i*8 +: 8] = wr_word[i*8 +: 8];
            end
        end
        rvalid_d = rd_req;
        rdata_d  = rdata_q;
        if (rd_req) begin
            rdata_d = (READ_MODE == WRITE_FIRST) ? merged_word : old_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [WIDTH-1:0] rdata_o_d, rdata_o_q;
    logic             rvalid_o_d, rvalid_o_q;

    always_comb begin
        rdata_o_d  = rdata_q;
        rvalid_o_d = rvalid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o_q  <= '0;
            rvalid_o_q <= 1'b0;
        end else begin
            rdata_o_q  <= rdata_o_d;
            rvalid_o_q <= rvalid_o_d;
        end
    end

    assign rdata  = rdata_o_q;
    assign rvalid = rvalid_o_q;
`else
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

endmodule

// File: rtl/dpram_tdp_ctrl.sv
// True dual-port RAM with byte enables, deterministic same-address collisions and a post-reset clear.
// Optional DPRAM_OUT_REG_EN adds one output register stage (rdata/rvalid/collision delayed together).
module dpram_tdp_ctrl
    import dpram_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  DEPTH     = 16,
    parameter int  READ_MODE = READ_FIRST,
    parameter int  PRIORITY  = PRIO_A,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB        = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [NB-1:0]     be_a,
    input  logic [WIDTH-1:0]  wdata_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [NB-1:0]     be_b,
    input  logic [WIDTH-1:0]  wdata_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b,
    output logic              collision,
    output state_e            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_e            state_d, state_q;
    logic [ADDR_W-1:0] ptr_d, ptr_q;
    logic              clr_we;
    logic              ready_int;

    logic              act_a, act_b, wr_a, wr_b, rd_a, rd_b;
    logic              in_a, in_b, same_addr, both_w;
    logic [NB-1:0]     be_a_eff, be_b_eff;
    logic [WIDTH-1:0]  old_a, old_b;
    logic              coll_d, coll_q;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ready_int = (state_q == ST_READY);
    assign ready     = ready_int;
    assign dbg_state = state_q;

    assign act_a     = ready_int & en_a;
    assign act_b     = ready_int & en_b;
    assign wr_a      = act_a & we_a;
    assign wr_b      = act_b & we_b;
    assign rd_a      = act_a & ~we_a;
    assign rd_b      = act_b & ~we_b;
    assign in_a      = (32'(addr_a) < 32'(DEPTH));
    assign in_b      = (32'(addr_b) < 32'(DEPTH));
    assign same_addr = (addr_a == addr_b);
    assign both_w    = wr_a & wr_b & same_addr;
    assign coll_d    = act_a & act_b & same_addr & (we_a | we_b);
    assign old_a     = in_a ? mem_q[addr_a] : '0;
    assign old_b     = in_b ? mem_q[addr_b] : '0;

    // Strip the losing port's contested bytes so the two write masks never overlap
    always_comb begin
        be_a_eff = (wr_a && in_a) ? be_a : '0;
        be_b_eff = (wr_b && in_b) ? be_b : '0;
        if (both_w) begin
            if (PRIORITY == PRIO_B) begin
                be_a_eff = be_a_eff & ~be_b;
            end else begin
                be_b_eff = be_b_eff & ~be_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[ptr_q] <= '0;
        end
        for (int i = 0; i < NB; i++) begin
            if (be_a_eff[i]) begin
                mem_q[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
            end
            if (be_b_eff[i]) begin
                mem_q[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
            end
        end
    end

    dpram_rd_port #(
        .WIDTH     (WIDTH),
        .READ_MODE (READ_MODE)
    ) u_rd_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_a),
        .old_word (old_a),
        .wr_word  (wdata_b),
        .wr_be    (same_addr ? be_b_eff : '0),
        .rdata    (rdata_a),
        .rvalid   (rvalid_a)
    );

    dpram_rd_port #(
        .WIDTH     (WIDTH),
        .READ_MODE (READ_MODE)
    ) u_rd_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_b),
        .old_word (old_b),
        .wr_word  (wdata_a),
        .wr_be    (same_addr ? be_a_eff : '0),
        .rdata    (rdata_b),
        .rvalid   (rvalid_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic coll_o_d, coll_o_q;

    assign coll_o_d = coll_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_o_q <= 1'b0;
        end else begin
            coll_o_q <= coll_o_d;
        end
    end

    assign collision = coll_o_q;
`else
    assign collision = coll_q;
`endif

endmodule

// File: tb/tb_dpram_tdp_ctrl.sv
// Bench for dpram_tdp_ctrl: two instances (8-bit read-first/prio A, 16-bit write-first/prio B)
// driven in lockstep, checked against a behavioural model through expected-result queues.
module tb_dpram_tdp_ctrl;
    import dpram_pkg::*;

`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the clear sequence: ready expected once 16 edges have elapsed out of reset
    int clr_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_cnt <= 0;
        else if (clr_cnt < 16) clr_cnt <= clr_cnt + 1;
    end

    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  addr_a, addr_b;
    logic        be_a0, be_b0;
    logic [1:0]  be_a1, be_b1;
    logic [7:0]  wdata_a0, wdata_b0;
    logic [15:0] wdata_a1, wdata_b1;

    logic        ready0, rvalid_a0, rvalid_b0, collision0;
    logic [7:0]  rdata_a0, rdata_b0;
    state_e      dbg_state0;
    logic        ready1, rvalid_a1, rvalid_b1, collision1;
    logic [15:0] rdata_a1, rdata_b1;
    state_e      dbg_state1;

    dpram_tdp_ctrl #(.WIDTH(8), .DEPTH(16), .READ_MODE(READ_FIRST), .PRIORITY(PRIO_A)) dut0 (
        .clk(clk), .rst_n(rst_n), .ready(ready0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .be_a(be_a0), .wdata_a(wdata_a0),
        .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .be_b(be_b0), .wdata_b(wdata_b0),
        .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
        .collision(collision0), .dbg_state(dbg_state0)
    );

    dpram_tdp_ctrl #(.WIDTH(16), .DEPTH(16), .READ_MODE(WRITE_FIRST), .PRIORITY(PRIO_B)) dut1 (
        .clk(clk), .rst_n(rst_n), .ready(ready1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .be_a(be_a1), .wdata_a(wdata_a1),
        .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .be_b(be_b1), .wdata_b(wdata_b1),
        .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
        .collision(collision1), .dbg_state(dbg_state1)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [2][16];
    logic [15:0] exp_q [4][$];
    int          due_q [4][$];
    int          coll_due_q [$];
    logic        ready_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_write(input int d, input logic en, input logic [3:0] a,
                             input logic [1:0] m, input logic [15:0] data);
        for (int i = 0; i < 2; i++) begin
            if (en && m[i]) mdl[d][a][i*8 +: 8] = data[i*8 +: 8];
        end
    endtask

    task automatic push_exp(input int p, input logic [15:0] v);
        exp_q[p].push_back(v);
        due_q[p].push_back(cyc + LAT);
    endtask

    task automatic monitor();
        logic [3:0]  obs_v;
        logic [15:0] obs_d [4];
        logic        exp_v;
        logic        coll_exp;
        chk("ready0", 32'(ready0), 32'(clr_cnt >= 16));
        chk("ready1", 32'(ready1), 32'(clr_cnt >= 16));
        ready_seen = ready0 & ready1;
        obs_v    = {rvalid_b1, rvalid_a1, rvalid_b0, rvalid_a0};
        obs_d[0] = {8'h00, rdata_a0};
        obs_d[1] = {8'h00, rdata_b0};
        obs_d[2] = rdata_a1;
        obs_d[3] = rdata_b1;
        for (int p = 0; p < 4; p++) begin
            while (due_q[p].size() > 0 && due_q[p][0] < cyc) begin
                void'(due_q[p].pop_front());
                void'(exp_q[p].pop_front());
            end
            exp_v = (due_q[p].size() > 0) && (due_q[p][0] == cyc);
            chk($sformatf("rvalid_p%0d", p), 32'(obs_v[p]), 32'(exp_v));
            if (exp_v) begin
                void'(due_q[p].pop_front());
                chk($sformatf("rdata_p%0d", p), 32'(obs_d[p]), 32'(exp_q[p].pop_front()));
            end
        end
        while (coll_due_q.size() > 0 && coll_due_q[0] < cyc) void'(coll_due_q.pop_front());
        coll_exp = (coll_due_q.size() > 0) && (coll_due_q[0] == cyc);
        if (coll_exp) void'(coll_due_q.pop_front());
        chk("collision0", 32'(collision0), 32'(coll_exp));
        chk("collision1", 32'(collision1), 32'(coll_exp));
    endtask

    // Drive one request cycle on both ports of both instances, update the model, check outputs
    task automatic step(input logic ea, input logic wa, input logic [3:0] aa,
                        input logic [1:0] ba, input logic [15:0] da,
                        input logic eb, input logic wb, input logic [3:0] ab,
                        input logic [1:0] bb, input logic [15:0] db);
        logic [15:0] old_a, old_b;
        logic [1:0]  ma, mb;
        en_a = ea; we_a = wa; addr_a = aa;
        en_b = eb; we_b = wb; addr_b = ab;
        be_a0 = ba[0]; be_a1 = ba; wdata_a0 = da[7:0]; wdata_a1 = da;
        be_b0 = bb[0]; be_b1 = bb; wdata_b0 = db[7:0]; wdata_b1 = db;
        if (clr_cnt >= 16) begin
            for (int d = 0; d < 2; d++) begin
                ma = (d == 0) ? {1'b0, ba[0]} : ba;
                mb = (d == 0) ? {1'b0, bb[0]} : bb;
                old_a = mdl[d][aa];
                old_b = mdl[d][ab];
                // the losing port is applied first so the winner overwrites contested bytes
                if (d == 0) begin
                    mdl_write(d, eb & wb, ab, mb, db);
                    mdl_write(d, ea & wa, aa, ma, da);
                end else begin
                    mdl_write(d, ea & wa, aa, ma, da);
                    mdl_write(d, eb & wb, ab, mb, db);
                end
                if (ea && !wa) push_exp(2*d,     (d == 1) ? mdl[d][aa] : old_a);
                if (eb && !wb) push_exp(2*d + 1, (d == 1) ? mdl[d][ab] : old_b);
            end
            if (ea && eb && (aa == ab) && (wa || wb)) coll_due_q.push_back(cyc + LAT);
        end
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 4; p++) begin
            exp_q[p].delete();
            due_q[p].delete();
        end
        coll_due_q.delete();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++) mdl[d][a] = 16'h0;
        #1;
        chk("rst_ready",  32'({ready1, ready0}), 32'd0);
        chk("rst_rvalid", 32'({rvalid_b1, rvalid_a1, rvalid_b0, rvalid_a0}), 32'd0);
        chk("rst_rdata0", 32'({rdata_b0, rdata_a0}), 32'd0);
        chk("rst_rdata1", 32'({rdata_b1, rdata_a1}), 32'd0);
        chk("rst_coll",   32'({collision1, collision0}), 32'd0);
    endtask

    task automatic wait_ready();
        int low;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (ready_seen) break;
            low++;
        end
        chk("ready_low_cycles", 32'(low), 32'd16);
    endtask

    initial begin
        en_a = 0; we_a = 0; addr_a = 0; be_a0 = 0; be_a1 = 0; wdata_a0 = 0; wdata_a1 = 0;
        en_b = 0; we_b = 0; addr_b = 0; be_b0 = 0; be_b1 = 0; wdata_b0 = 0; wdata_b1 = 0;
        ready_seen = 1'b0;
        rst_n = 1'b1;
        #2;
        do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready();

        // Cleared contents on both ports
        for (int i = 0; i < 16; i++)
            step(1, 0, 4'(i), 2'b00, 16'h0, 1, 0, 4'(15 - i), 2'b00, 16'h0);

        // Independent writes then cross reads
        step(1, 1, 4'd0, 2'b11, 16'h55AA, 1, 1, 4'd1, 2'b11, 16'h3412);
        step(1, 0, 4'd1, 2'b00, 16'h0,    1, 0, 4'd0, 2'b00, 16'h0);

        // Write/write collisions: full overlap, then partial byte overlap
        step(1, 1, 4'd3, 2'b11, 16'hC3F1, 1, 1, 4'd3, 2'b11, 16'h7E3A);
        step(1, 0, 4'd3, 2'b00, 16'h0,    1, 0, 4'd3, 2'b00, 16'h0);
        step(1, 1, 4'd4, 2'b11, 16'h1111, 1, 1, 4'd4, 2'b10, 16'h2222);
        step(1, 0, 4'd4, 2'b00, 16'h0,    1, 0, 4'd4, 2'b00, 16'h0);

        // Read/write collisions in both directions
        step(1, 1, 4'd5, 2'b11, 16'h9956, 0, 0, 4'd0, 2'b00, 16'h0);
        step(1, 0, 4'd5, 2'b00, 16'h0,    1, 1, 4'd5, 2'b11, 16'h115A);
        step(1, 1, 4'd5, 2'b10, 16'hEE00, 1, 0, 4'd5, 2'b00, 16'h0);
        step(1, 0, 4'd5, 2'b00, 16'h0,    1, 0, 4'd5, 2'b00, 16'h0);

        // Byte-enable merge and an all-zero byte-enable write
        step(1, 1, 4'd7, 2'b11, 16'h1234, 0, 0, 4'd0, 2'b00, 16'h0);
        step(1, 1, 4'd7, 2'b10, 16'hABCD, 0, 0, 4'd0, 2'b00, 16'h0);
        step(0, 0, 4'd0, 2'b00, 16'h0,    1, 1, 4'd7, 2'b00, 16'hFFFF);
        step(1, 0, 4'd7, 2'b00, 16'h0,    0, 0, 4'd0, 2'b00, 16'h0);

        // Random traffic over a narrow address range to provoke collisions
        for (int i = 0; i < 48; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
        end
        for (int i = 0; i < LAT + 1; i++) idle();

        // Reset while a read response is in flight
        step(1, 1, 4'd0, 2'b11, 16'hBEEF, 0, 0, 4'd0, 2'b00, 16'h0);
        step(1, 0, 4'd0, 2'b00, 16'h0,    1, 0, 4'd0, 2'b00, 16'h0);
        #1;
        do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Requests during clear are ignored, then reset again mid-clear
        for (int i = 0; i < 5; i++) idle();
        step(1, 1, 4'd2, 2'b11, 16'hDEAD, 1, 0, 4'd2, 2'b00, 16'h0);
        step(1, 0, 4'd2, 2'b00, 16'h0,    1, 1, 4'd3, 2'b11, 16'hCAFE);
        do_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready();
        for (int i = 0; i < 4; i++)
            step(1, 0, 4'(i), 2'b00, 16'h0, 1, 0, 4'(i + 4), 2'b00, 16'h0);
        for (int i = 0; i < LAT + 2; i++) idle();

        chk("queues_drained",
            32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()
                + coll_due_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
